// File: rtl/hex_text_parser_pkg.sv
// Shared constants and state encoding for the ASCII hex line parser.
// Reused by the character decoder and the parser top.
package hex_text_pkg;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_BS   = 8'h08;
  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_A_UP = 8'h41;
  localparam logic [7:0] CHAR_A_LO = 8'h61;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/hex_text_parser_decode.sv
// Combinational ASCII character classifier: hex digit value,
// line terminator and backspace flags.
module hex_char_decode
  import hex_text_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_term,
  output logic       is_bs
);

  logic dec, up, lo;

  assign dec = (char_in >= CHAR_0) &&
               (char_in <= CHAR_0 + 8'd9);
  assign up  = (char_in >= CHAR_A_UP) &&
               (char_in <= CHAR_A_UP + 8'd5);
  assign lo  = (char_in >= CHAR_A_LO) &&
               (char_in <= CHAR_A_LO + 8'd5);

  always_comb begin
    nibble  = 4'h0;
    is_hex  = 1'b0;
    is_term = (char_in == CHAR_CR) ||
              (char_in == CHAR_LF);
    is_bs   = (char_in == CHAR_BS);
    unique case (1'b1)
      dec: begin
        is_hex = 1'b1;
        nibble = 4'(char_in - CHAR_0);
      end
      up: begin
        is_hex = 1'b1;
        nibble = 4'(char_in - CHAR_A_UP + 8'd10);
      end
      lo: begin
        is_hex = 1'b1;
        nibble = 4'(char_in - CHAR_A_LO + 8'd10);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hex_text_parser.sv
// Assembles a CR/LF terminated line of hex text into a binary value,
// pulsing value_valid on success or error on a bad line.
module hex_text_parser
  import hex_text_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic [WIDTH-1:0] value_out,
  output logic             value_valid,
  output logic             error,
  output logic             busy
);

  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] nibble;
  logic is_hex, is_term, is_bs;
  logic top_busy;
  logic vv_d, err_d;

  hex_char_decode u_dec (
    .char_in (char_in),
    .nibble  (nibble),
    .is_hex  (is_hex),
    .is_term (is_term),
    .is_bs   (is_bs)
  );

  // A nonzero top nibble means one more shift would lose bits.
  assign top_busy = |acc_q[WIDTH-1:WIDTH-4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (char_valid) begin
      case (state_q)
        IDLE: begin
          if (is_hex)
            state_d = DIGITS;
          else if (!is_term && !is_bs)
            state_d = DRAIN;
        end
        DIGITS: begin
          if (is_term)
            state_d = IDLE;
          else if (is_bs) begin
            if (cnt_q == CNT_W'(1))
              state_d = IDLE;
          end else if (!is_hex || top_busy)
            state_d = DRAIN;
        end
        DRAIN: begin
          if (is_term)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    vv_d  = 1'b0;
    err_d = 1'b0;
    if (char_valid) begin
      case (state_q)
        IDLE: begin
          if (is_hex) begin
            acc_d = WIDTH'(nibble);
            cnt_d = CNT_W'(1);
          end
        end
        DIGITS: begin
          if (is_term)
            vv_d = 1'b1;
          else if (is_bs) begin
            acc_d = acc_q >> 4;
            cnt_d = cnt_q - CNT_W'(1);
          end else if (is_hex && !top_busy) begin
            acc_d = {acc_q[WIDTH-5:0], nibble};
            if (cnt_q != '1)
              cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DRAIN: err_d = is_term;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      value_valid <= vv_d;
      error       <= err_d;
      busy        <= (state_d != IDLE);
      if (vv_d)
        value_out <= acc_q;
    end
  end

endmodule

// File: tb/tb_hex_text_parser.sv
// Bench for hex_text_parser: directed line scenarios plus a randomized
// character stream compared against a line-level reference model.
module tb_hex_text_parser;
  import hex_text_pkg::*;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   char_in;
  logic         char_valid;
  logic [W-1:0] value_out;
  logic         value_valid;
  logic         error;
  logic         busy;

  int errors = 0;
  int checks = 0;

  int n_vv;
  int n_err;
  bit both_seen = 1'b0;

  int           m_acc;
  int           m_cnt;
  bit           m_active;
  bit           m_bad;
  logic [W-1:0] m_val;
  bit           e_vv;
  bit           e_err;

  always #5 clk = ~clk;

  hex_text_parser dut (
    .clk         (clk),
    .reset       (reset),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .value_out   (value_out),
    .value_valid (value_valid),
    .error       (error),
    .busy        (busy)
  );

  task automatic model_reset();
    m_acc = 0; m_cnt = 0;
    m_active = 0; m_bad = 0;
    m_val = '0; e_vv = 0; e_err = 0;
  endtask

  // Line-level model: a line is either good (digits so far) or bad.
  task automatic model_step(input logic [7:0] c);
    bit hx, tm, bs;
    int nib;
    hx = 0; nib = 0;
    if (c >= 8'h30 && c <= 8'h39) begin hx = 1; nib = c - 48; end
    if (c >= 8'h41 && c <= 8'h46) begin hx = 1; nib = c - 55; end
    if (c >= 8'h61 && c <= 8'h66) begin hx = 1; nib = c - 87; end
    tm = (c == 8'h0D) || (c == 8'h0A);
    bs = (c == 8'h08);
    e_vv = 0; e_err = 0;
    if (!m_active) begin
      if (hx) begin
        m_acc = nib; m_cnt = 1;
        m_active = 1; m_bad = 0;
      end else if (!tm && !bs) begin
        m_active = 1; m_bad = 1;
      end
    end else if (m_bad) begin
      if (tm) begin e_err = 1; m_active = 0; end
    end else if (hx) begin
      if (m_acc >= (1 << (W - 4))) m_bad = 1;
      else begin
        m_acc = m_acc * 16 + nib;
        m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
      end
    end else if (bs) begin
      m_acc = m_acc / 16;
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_active = 0;
    end else if (tm) begin
      e_vv = 1; m_val = W'(m_acc); m_active = 0;
    end else begin
      m_bad = 1;
    end
  endtask

  task automatic sample();
    n_vv  += int'(value_valid);
    n_err += int'(error);
    if (value_valid && error) both_seen = 1'b1;
  endtask

  task automatic send(input logic [7:0] c);
    char_in = c;
    char_valid = 1'b1;
    model_step(c);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    sample();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic clear_counts();
    n_vv = 0; n_err = 0;
  endtask

  task automatic do_reset();
    char_valid = 1'b0;
    char_in = 8'h00;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (value_out !== '0) begin
      errors++;
      $display("FAIL reset_value: got %h want 0", value_out);
    end
    checks++;
    if ({value_valid, error, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: vv/err/busy got %b want 000",
               {value_valid, error, busy});
    end
  endtask

  task automatic test_max_value();
    clear_counts();
    send_str("3FFFF\r");
    checks++;
    if (value_valid !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL max_pulse: vv=%b err=%b want vv=1 err=0",
               value_valid, error);
    end
    checks++;
    if (value_out !== 18'h3FFFF) begin
      errors++;
      $display("FAIL max_value: got %h want 3ffff", value_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL max_busy: got %b want 0", busy);
    end
    idle_cycle();
    checks++;
    if (value_valid !== 1'b0 || n_vv != 1 || n_err != 0) begin
      errors++;
      $display("FAIL max_single: vv=%b n_vv=%0d n_err=%0d want 0/1/0",
               value_valid, n_vv, n_err);
    end
  endtask

  task automatic test_case_and_terms();
    clear_counts();
    send_str("1a2B\n");
    checks++;
    if (value_out !== 18'h01A2B || n_vv != 1) begin
      errors++;
      $display("FAIL mixed_case: got %h n_vv=%0d want 01a2b 1",
               value_out, n_vv);
    end
    clear_counts();
    send_str("\r\n\r");
    idle_cycle();
    checks++;
    if (n_vv != 0 || n_err != 0 || value_out !== 18'h01A2B) begin
      errors++;
      $display("FAIL empty_lines: n_vv=%0d n_err=%0d val=%h want 0 0 01a2b",
               n_vv, n_err, value_out);
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_str("40000\r");
    checks++;
    if (error !== 1'b1 || n_err != 1 || n_vv != 0) begin
      errors++;
      $display("FAIL overflow: err=%b n_err=%0d n_vv=%0d want 1 1 0",
               error, n_err, n_vv);
    end
    checks++;
    if (value_out !== 18'h01A2B) begin
      errors++;
      $display("FAIL overflow_hold: got %h want 01a2b", value_out);
    end
    clear_counts();
    send_str("000003FFFF\r");
    checks++;
    if (value_out !== 18'h3FFFF || n_vv != 1 || n_err != 0) begin
      errors++;
      $display("FAIL lead_zeros: got %h n_vv=%0d n_err=%0d want 3ffff 1 0",
               value_out, n_vv, n_err);
    end
  endtask

  task automatic test_illegal();
    clear_counts();
    send_str("12G4");
    checks++;
    if (busy !== 1'b1 || n_err != 0) begin
      errors++;
      $display("FAIL drain_busy: busy=%b n_err=%0d want 1 0", busy, n_err);
    end
    send_str("\r");
    checks++;
    if (error !== 1'b1 || value_valid !== 1'b0 || n_err != 1) begin
      errors++;
      $display("FAIL illegal: err=%b vv=%b n_err=%0d want 1 0 1",
               error, value_valid, n_err);
    end
    send_str("7\r");
    checks++;
    if (value_valid !== 1'b1 || value_out !== 18'h00007) begin
      errors++;
      $display("FAIL recover: vv=%b val=%h want 1 00007",
               value_valid, value_out);
    end
  endtask

  task automatic test_backspace();
    clear_counts();
    send_str("ABC");
    send(CHAR_BS);
    send(CHAR_BS);
    send_str("5\r");
    checks++;
    if (value_out !== 18'h000A5 || n_vv != 1) begin
      errors++;
      $display("FAIL backspace: got %h n_vv=%0d want 000a5 1",
               value_out, n_vv);
    end
    clear_counts();
    send_str("9");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bs_busy_on: got %b want 1", busy);
    end
    send(CHAR_BS);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bs_empty: busy got %b want 0", busy);
    end
    send_str("\r");
    idle_cycle();
    checks++;
    if (n_vv != 0 || n_err != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bs_noline: n_vv=%0d n_err=%0d busy=%b want 0 0 0",
               n_vv, n_err, busy);
    end
  endtask

  task automatic test_reset_midline();
    clear_counts();
    send_str("12");
    do_reset();
    send_str("\r");
    idle_cycle();
    checks++;
    if (n_vv != 0 || n_err != 0 || value_out !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: n_vv=%0d n_err=%0d val=%h busy=%b want 0 0 0 0",
               n_vv, n_err, value_out, busy);
    end
    send_str("F\r");
    checks++;
    if (value_out !== 18'h0000F || value_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: val=%h vv=%b want 0000f 1",
               value_out, value_valid);
    end
  endtask

  task automatic test_random();
    string hs;
    logic [7:0] c;
    int r;
    bit gap;
    hs = "0123456789abcdefABCDEF";
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 62)      c = hs[$urandom_range(0, 21)];
      else if (r < 76) c = ($urandom_range(0, 1) != 0) ? CHAR_CR : CHAR_LF;
      else if (r < 88) c = CHAR_BS;
      else             c = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 3) == 0);
      if (gap && i > 0) begin
        idle_cycle();
        e_vv = 0; e_err = 0;
      end else begin
        send(c);
      end
      checks++;
      if (value_valid !== e_vv || error !== e_err) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: vv=%b err=%b want %b %b",
                 i, value_valid, error, e_vv, e_err);
      end
      checks++;
      if (busy !== m_active) begin
        errors++;
        $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, m_active);
      end
      checks++;
      if (value_out !== m_val) begin
        errors++;
        $display("FAIL rand_value[%0d]: got %h want %h", i, value_out, m_val);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    char_valid = 1'b0;
    char_in = 8'h00;
    clear_counts();
    test_reset();
    test_max_value();
    test_case_and_terms();
    test_overflow();
    test_illegal();
    test_backspace();
    test_reset_midline();
    test_random();
    checks++;
    if (both_seen) begin
      errors++;
      $display("FAIL exclusive: value_valid and error high together");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
